// File: rtl/tile_draw_datapath.sv
// tile_draw_datapath
//   Pixel datapath for the 2x2 Simon tile grid, driven by graphics_control strobes.
//   Holds the LFSR tile picker, the current-tile origin/colour registers, the
//   8x8 pixel scan counter, the registered VGA output stage and the store of
//   flashed tiles read back by the player-input checker.
//
//   Optional feature macro: NO_REPEAT_EN -- a random pick equal to the last
//   stored tile is bumped to (tile+1) mod 4.
//
// Ports
//   clock, resetn            clock (posedge), async active-low reset
//   ld_tile, ld_flash        load tile origin/base colour, load flash colour
//   writeEnable              pixel write request (appears on plot one cycle later)
//   counterEnable            advance pixel counter
//   randomEnable             step LFSR; with ld_tile picks a random tile
//   hold_tile, tile_num      tile select for non-random ld_tile
//   seq_clear, seq_rd_idx    sequence store clear / read index
//   seq_rd_tile, seq_len,
//   seq_full                 sequence store read data and fill state
//   cur_tile                 tile currently loaded
//   x, y, colour, plot       registered VGA pixel write
//   tile_done                pulse after the last pixel of a tile is counted
module tile_draw_datapath #(
   parameter int          TILE_SIZE = 8,
   parameter int          TILE_GAP  = 16,
   parameter int          GRID_X0   = 64,
   parameter int          GRID_Y0   = 44,
   parameter logic [7:0]  LFSR_SEED = 8'hA5,
   parameter int          SEQ_DEPTH = 16
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       ld_tile,
   input  logic       ld_flash,
   input  logic       writeEnable,
   input  logic       counterEnable,
   input  logic       randomEnable,
   input  logic       hold_tile,
   input  logic [1:0] tile_num,
   input  logic       seq_clear,
   input  logic [3:0] seq_rd_idx,
   output logic [1:0] seq_rd_tile,
   output logic [4:0] seq_len,
   output logic       seq_full,
   output logic [1:0] cur_tile,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       tile_done
);

   localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam logic [7:0] X0   = 8'(GRID_X0);
   localparam logic [6:0] Y0   = 7'(GRID_Y0);
   localparam logic [7:0] PX   = 8'(TILE_SIZE + TILE_GAP);
   localparam logic [6:0] PY   = 7'(TILE_SIZE + TILE_GAP);
   localparam logic [4:0] DEPTH = 5'(SEQ_DEPTH);

   logic [7:0] lfsr, lfsr_nxt;
   logic [5:0] pix_cnt;
   logic [2:0] colour_reg;
   logic [7:0] org_x;
   logic [6:0] org_y;
   logic [1:0] rnd_tile, t_sel;
   logic       seq_wr;
   logic [1:0] seq_mem [SEQ_DEPTH];

   function automatic logic [2:0] base_col(input logic [1:0] t);
      case (t)
         2'd0:    return 3'b100;
         2'd1:    return 3'b010;
         2'd2:    return 3'b001;
         default: return 3'b110;
      endcase
   endfunction

   // Fibonacci LFSR, taps 7/5/4/3; the all-zero lock-up state is escaped to 1.
   always_comb begin
      lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (lfsr_nxt == 8'h00) lfsr_nxt = 8'h01;
   end

`ifdef NO_REPEAT_EN
   logic [4:0] last_idx;
   logic [1:0] last_tile;
   always_comb begin
      last_idx  = seq_len - 5'd1;
      last_tile = seq_mem[last_idx[3:0]];
      rnd_tile  = lfsr[1:0];
      if (seq_len != 5'd0 && rnd_tile == last_tile) rnd_tile = rnd_tile + 2'd1;
   end
`else
   assign rnd_tile = lfsr[1:0];
`endif

   always_comb begin
      if (randomEnable)   t_sel = rnd_tile;
      else if (hold_tile) t_sel = cur_tile;
      else                t_sel = tile_num;
   end

   assign seq_full = (seq_len == DEPTH);
   assign seq_wr   = ld_tile && randomEnable && !seq_full && !seq_clear;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         lfsr       <= SEED;
         cur_tile   <= 2'd0;
         colour_reg <= 3'd0;
         org_x      <= X0;
         org_y      <= Y0;
         pix_cnt    <= 6'd0;
         seq_len    <= 5'd0;
         x          <= 8'd0;
         y          <= 7'd0;
         colour     <= 3'd0;
         plot       <= 1'b0;
         tile_done  <= 1'b0;
      end else begin
         if (randomEnable) lfsr <= lfsr_nxt;

         if (ld_tile) begin
            cur_tile   <= t_sel;
            org_x      <= X0 + (t_sel[0] ? PX : 8'd0);
            org_y      <= Y0 + (t_sel[1] ? PY : 7'd0);
            colour_reg <= base_col(t_sel);
         end
         // Flash colour overrides a same-cycle tile load.
         if (ld_flash) colour_reg <= 3'b111;

         if (ld_tile || ld_flash)  pix_cnt <= 6'd0;
         else if (counterEnable)   pix_cnt <= pix_cnt + 6'd1;

         tile_done <= counterEnable && !(ld_tile || ld_flash) && (pix_cnt == 6'd63);

         // Coordinates and colour sampled in the same edge so a colour change
         // can never land on a partly drawn pixel.
         plot <= writeEnable;
         if (writeEnable) begin
            x      <= org_x + {5'd0, pix_cnt[2:0]};
            y      <= org_y + {4'd0, pix_cnt[5:3]};
            colour <= colour_reg;
         end

         if (seq_clear)   seq_len <= 5'd0;
         else if (seq_wr) seq_len <= seq_len + 5'd1;
      end
   end

   // Storage needs no reset: reads are masked by seq_len.
   always_ff @(posedge clock) begin
      if (seq_wr) seq_mem[seq_len[3:0]] <= t_sel;
   end

   always_comb begin
      seq_rd_tile = 2'b00;
      if ({1'b0, seq_rd_idx} < seq_len) seq_rd_tile = seq_mem[seq_rd_idx];
   end

endmodule

// File: tb/tb_tile_draw_datapath.sv
module tb_tile_draw_datapath;

   logic       clock = 1'b0;
   logic       resetn;
   logic       ld_tile, ld_flash, writeEnable, counterEnable, randomEnable, hold_tile;
   logic [1:0] tile_num;
   logic       seq_clear;
   logic [3:0] seq_rd_idx;
   logic [1:0] seq_rd_tile;
   logic [4:0] seq_len;
   logic       seq_full;
   logic [1:0] cur_tile;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, tile_done;

   tile_draw_datapath dut (
      .clock(clock), .resetn(resetn), .ld_tile(ld_tile), .ld_flash(ld_flash),
      .writeEnable(writeEnable), .counterEnable(counterEnable),
      .randomEnable(randomEnable), .hold_tile(hold_tile), .tile_num(tile_num),
      .seq_clear(seq_clear), .seq_rd_idx(seq_rd_idx), .seq_rd_tile(seq_rd_tile),
      .seq_len(seq_len), .seq_full(seq_full), .cur_tile(cur_tile), .x(x), .y(y),
      .colour(colour), .plot(plot), .tile_done(tile_done)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int m_lfsr, m_cur, m_col, m_ox, m_oy, m_pix;
   int m_x, m_y, m_colour, m_plot, m_done;
   int q[$];
   int base[4] = '{4, 2, 1, 6};

   task automatic model_reset();
      m_lfsr = 'hA5; m_cur = 0; m_col = 0; m_ox = 64; m_oy = 44; m_pix = 0;
      m_x = 0; m_y = 0; m_colour = 0; m_plot = 0; m_done = 0;
      q.delete();
   endtask

   function automatic int lfsr_step(input int l);
      int fb, n;
      fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
      n = ((l * 2) % 256) + fb;
      return (n == 0) ? 1 : n;
   endfunction

   task automatic model_step(input bit lt, lf, we, ce, re, hold, input int tn, input bit clr);
      int t, rnd;
      rnd = m_lfsr % 4;
`ifdef NO_REPEAT_EN
      if (q.size() > 0 && rnd == q[q.size()-1]) rnd = (rnd + 1) % 4;
`endif
      m_plot = we;
      if (we) begin
         m_x = m_ox + m_pix % 8;
         m_y = m_oy + m_pix / 8;
         m_colour = m_col;
      end
      m_done = (ce && !(lt || lf) && m_pix == 63) ? 1 : 0;
      if (lt || lf) m_pix = 0;
      else if (ce) m_pix = (m_pix + 1) % 64;
      if (lt) begin
         t = re ? rnd : (hold ? m_cur : tn);
         m_cur = t;
         m_ox = 64 + (t % 2) * 24;
         m_oy = 44 + (t / 2) * 24;
         m_col = base[t];
      end
      if (lf) m_col = 7;
      if (clr) q.delete();
      else if (lt && re && q.size() < 16) q.push_back(t);
      if (re) m_lfsr = lfsr_step(m_lfsr);
   endtask

   task automatic compare_all(input int idx);
      chk("x", 32'(x), 32'(m_x));
      chk("y", 32'(y), 32'(m_y));
      chk("colour", 32'(colour), 32'(m_colour));
      chk("plot", 32'(plot), 32'(m_plot));
      chk("tile_done", 32'(tile_done), 32'(m_done));
      chk("cur_tile", 32'(cur_tile), 32'(m_cur));
      chk("seq_len", 32'(seq_len), 32'(q.size()));
      chk("seq_full", 32'(seq_full), 32'(q.size() == 16));
      chk("seq_rd_tile", 32'(seq_rd_tile), 32'((idx < q.size()) ? q[idx] : 0));
   endtask

   task automatic cycle(input bit lt, lf, we, ce, re, hold, input logic [1:0] tn,
                        input bit clr, input logic [3:0] idx);
      ld_tile = lt; ld_flash = lf; writeEnable = we; counterEnable = ce;
      randomEnable = re; hold_tile = hold; tile_num = tn; seq_clear = clr;
      seq_rd_idx = idx;
      @(posedge clock);
      model_step(lt, lf, we, ce, re, hold, int'(tn), clr);
      #1;
      compare_all(int'(idx));
   endtask

   task automatic idle_inputs();
      ld_tile = 0; ld_flash = 0; writeEnable = 0; counterEnable = 0;
      randomEnable = 0; hold_tile = 0; tile_num = 0; seq_clear = 0; seq_rd_idx = 0;
   endtask

   // Pulse reset between edges (called just after a posedge).
   task automatic do_reset();
      idle_inputs();
      #2 resetn = 0;
      #2 resetn = 1;
      model_reset();
   endtask

   typedef struct {
      bit lt, lf, we, ce, hold;
      logic [1:0] tn;
      logic [1:0] e_cur;
      logic [7:0] e_x;
      logic [6:0] e_y;
      logic [2:0] e_col;
      logic       e_plot;
   } vec_t;
   vec_t tbl[12];

   initial begin
      int dones;
      tbl[0]  = '{1,0,0,0,0, 2'd2, 2'd2,  8'd0,  7'd0, 3'd0, 1'b0};
      tbl[1]  = '{0,0,1,1,0, 2'd0, 2'd2, 8'd64, 7'd68, 3'd1, 1'b1};
      tbl[2]  = '{0,0,1,1,0, 2'd0, 2'd2, 8'd65, 7'd68, 3'd1, 1'b1};
      tbl[3]  = '{0,0,0,0,0, 2'd0, 2'd2, 8'd65, 7'd68, 3'd1, 1'b0};
      tbl[4]  = '{0,1,0,0,0, 2'd0, 2'd2, 8'd65, 7'd68, 3'd1, 1'b0};
      tbl[5]  = '{0,0,1,0,0, 2'd0, 2'd2, 8'd64, 7'd68, 3'd7, 1'b1};
      tbl[6]  = '{1,0,0,0,1, 2'd0, 2'd2, 8'd64, 7'd68, 3'd7, 1'b0};
      tbl[7]  = '{0,0,1,0,0, 2'd0, 2'd2, 8'd64, 7'd68, 3'd1, 1'b1};
      tbl[8]  = '{1,0,0,0,0, 2'd3, 2'd3, 8'd64, 7'd68, 3'd1, 1'b0};
      tbl[9]  = '{0,0,1,0,0, 2'd0, 2'd3, 8'd88, 7'd68, 3'd6, 1'b1};
      tbl[10] = '{1,1,0,0,0, 2'd1, 2'd1, 8'd88, 7'd68, 3'd6, 1'b0};
      tbl[11] = '{0,0,1,0,0, 2'd0, 2'd1, 8'd88, 7'd44, 3'd7, 1'b1};

      // reset values
      idle_inputs();
      resetn = 0;
      model_reset();
      #12;
      chk("rst_plot", 32'(plot), 0);
      chk("rst_xyc", {x, 1'b0, y, 5'd0, colour}, 0);
      chk("rst_done", 32'(tile_done), 0);
      chk("rst_cur", 32'(cur_tile), 0);
      chk("rst_len", 32'(seq_len), 0);
      chk("rst_lfsr", 32'(dut.lfsr), 32'hA5);
      chk("rst_org", {dut.org_x, 1'b0, dut.org_y}, {8'd64, 1'b0, 7'd44});
      @(negedge clock) resetn = 1;

      // first load: tile 2
      cycle(1,0,0,0,0,0, 2'd2, 0, 0);
      chk("ld2_org", {dut.org_x, 1'b0, dut.org_y}, {8'd64, 1'b0, 7'd68});
      chk("ld2_colreg", 32'(dut.colour_reg), 32'b001);
      chk("ld2_pix", 32'(dut.pix_cnt), 0);

      // table-driven vectors (vector 0 repeats the load above)
      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i].lt, tbl[i].lf, tbl[i].we, tbl[i].ce, 0, tbl[i].hold, tbl[i].tn, 0, 0);
         chk($sformatf("tbl%0d_cur", i), 32'(cur_tile), 32'(tbl[i].e_cur));
         chk($sformatf("tbl%0d_x", i), 32'(x), 32'(tbl[i].e_x));
         chk($sformatf("tbl%0d_y", i), 32'(y), 32'(tbl[i].e_y));
         chk($sformatf("tbl%0d_col", i), 32'(colour), 32'(tbl[i].e_col));
         chk($sformatf("tbl%0d_plot", i), 32'(plot), 32'(tbl[i].e_plot));
      end

      // flash then hold-reload on tile 3
      cycle(1,0,0,0,0,0, 2'd3, 0, 0);
      cycle(0,1,0,0,0,0, 2'd0, 0, 0);
      cycle(0,0,1,0,0,0, 2'd0, 0, 0);
      chk("flash_col", 32'(colour), 32'b111);
      cycle(1,0,0,0,0,1, 2'd0, 0, 0);
      cycle(0,0,1,0,0,0, 2'd0, 0, 0);
      chk("hold_col", 32'(colour), 32'b110);
      chk("hold_xy", {x, 1'b0, y}, {8'd88, 1'b0, 7'd68});

      // full tile draw
      cycle(1,0,0,0,0,0, 2'd2, 0, 0);
      dones = 0;
      for (int i = 0; i < 64; i++) begin
         cycle(0,0,1,1,0,0, 2'd0, 0, 0);
         if (i == 0) chk("draw_first", {x, 1'b0, y}, {8'd64, 1'b0, 7'd68});
         if (tile_done) dones++;
      end
      chk("draw_last", {x, 1'b0, y}, {8'd71, 1'b0, 7'd75});
      chk("draw_done_last", 32'(tile_done), 1);
      chk("draw_pix_wrap", 32'(dut.pix_cnt), 0);
      cycle(0,0,0,0,0,0, 2'd0, 0, 0);
      chk("draw_done_cnt", dones, 1);

      // random pick from seed
      do_reset();
      cycle(0,0,0,0,0,0, 2'd0, 1, 0);
      cycle(1,0,0,0,1,0, 2'd0, 0, 0);
      chk("rnd_cur", 32'(cur_tile), 1);
      chk("rnd_lfsr", 32'(dut.lfsr), 32'h4A);
      chk("rnd_len", 32'(seq_len), 1);
      chk("rnd_rd0", 32'(seq_rd_tile), 1);

      // fill the sequence store past depth
      cycle(0,0,0,0,0,0, 2'd0, 1, 0);
      for (int i = 0; i < 17; i++) cycle(1,0,0,0,1,0, 2'd0, 0, 4'(i));
      chk("full_len", 32'(seq_len), 16);
      chk("full_flag", 32'(seq_full), 1);
      for (int i = 0; i < 16; i++) cycle(0,0,0,0,0,0, 2'd0, 0, 4'(i));
      cycle(0,0,0,0,0,0, 2'd0, 1, 4'd0);
      chk("clr_rd", 32'(seq_rd_tile), 0);

      // async reset mid-draw
      cycle(1,0,0,0,1,0, 2'd0, 0, 0);
      for (int i = 0; i < 30; i++) cycle(0,0,1,1,1,0, 2'd0, 0, 0);
      chk("mid_pix", 32'(dut.pix_cnt), 30);
      #2 resetn = 0;
      #1;
      chk("mid_plot", 32'(plot), 0);
      chk("mid_pix0", 32'(dut.pix_cnt), 0);
      chk("mid_lfsr", 32'(dut.lfsr), 32'hA5);
      idle_inputs();
      model_reset();
      #1 resetn = 1;

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         cycle($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
               2'($urandom_range(0, 3)), $urandom_range(0, 63) == 0,
               4'($urandom_range(0, 15)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
